// File: rtl/srl_iter.sv
// Multi-cycle right shifter (logical or arithmetic) applying one log2 stage
// per clock (1, 2, 4, 8, 16), with valid/ready handshakes on both sides.
module srl_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      movement,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned CW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CW-1:0] LAST = CW'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [WIDTH-1:0]        work, work_d;
  logic [SHW-1:0]          shamt, shamt_d;
  logic                    arith_q, arith_d;
  logic [SHW-1:0]          amt;
  logic [WIDTH-1:0]        srl_v;
  logic signed [WIDTH-1:0] sra_v;
  logic                    unused_mv;

  // Upper shift-amount bits are deliberately ignored.
  assign unused_mv = ^movement[31:SHW];

  // Stage shift distance 2^cnt; sign fill kept in a fully signed expression.
  assign amt   = SHW'(1) << cnt;
  assign srl_v = work >> amt;
  assign sra_v = $signed(work) >>> amt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      shamt   <= '0;
      arith_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      work    <= work_d;
      shamt   <= shamt_d;
      arith_q <= arith_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    work_d  = work;
    shamt_d = shamt;
    arith_d = arith_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_d  = a;
          shamt_d = movement[SHW-1:0];
          arith_d = arith;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shamt[cnt]) begin
          work_d = arith_q ? WIDTH'(sra_v) : srl_v;
        end
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decoded straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = work;

endmodule

// File: tb/tb_srl_iter.sv
// Directed and randomised checks of the iterative right shifter.
module tb_srl_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] movement;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  srl_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .movement(movement), .arith(arith),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for random ops: plain full-width shift.
  function automatic logic [31:0] ref_shift(input logic [31:0] av, input logic [31:0] mv,
                                             input logic ar);
    logic signed [31:0] s;
    s = $signed(av) >>> mv[4:0];
    return ar ? 32'(s) : (av >> mv[4:0]);
  endfunction

  // One full operation: accept, check latency, stall, take result.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] mv,
                       input logic ar, input logic [31:0] exp, input int stall,
                       input bit noisy);
    int guard;
    int lat;
    a = av; movement = mv; arith = ar; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = $urandom; movement = $urandom; arith = 1'($urandom);
    check({tag, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noisy) out_ready = 1'($urandom);
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_out"}, out, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      if (out_valid !== 1'b1 || out !== exp) check({tag, "_stall"}, out, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_taken"}, {30'd0, out_valid, in_ready}, 32'd1);
    check({tag, "_hold"}, out, exp);
  endtask

  initial begin
    logic [31:0] ra, rm, held;
    logic        rr;
    int          guard;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; movement = '0; arith = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out", out, 32'd0);
    check("rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op("srl4",    32'h8000_0000, 32'd4,          1'b0, 32'h0800_0000, 2, 1'b0);
    do_op("sra4",    32'h8000_0000, 32'd4,          1'b1, 32'hF800_0000, 0, 1'b0);
    do_op("sra31",   32'hFFFF_FFFF, 32'd31,         1'b1, 32'hFFFF_FFFF, 1, 1'b0);
    do_op("srl31",   32'hFFFF_FFFF, 32'd31,         1'b0, 32'h0000_0001, 0, 1'b0);
    do_op("mask0",   32'h1234_5678, 32'hFFFF_FFE0,  1'b1, 32'h1234_5678, 0, 1'b0);
    do_op("sra31p",  32'h7FFF_FFFF, 32'd31,         1'b1, 32'h0000_0000, 0, 1'b0);
    do_op("srl16",   32'h8765_4321, 32'd16,         1'b0, 32'h0000_8765, 0, 1'b0);
    do_op("sra16",   32'h8765_4321, 32'h0000_0030,  1'b1, 32'hFFFF_8765, 0, 1'b0);
    do_op("sra21",   32'hA5A5_0000, 32'd21,         1'b1, 32'hFFFF_FD2D, 0, 1'b1);

    // Backpressure: result held while a second request waits.
    do_op("bp_first", 32'hC000_0000, 32'd1, 1'b1, 32'hE000_0000, 0, 1'b0);
    a = 32'h0000_FF00; movement = 32'd8; arith = 1'b0; in_valid = 1'b1;
    tick();
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    // The request above was accepted from IDLE; now stall its result.
    check("bp_valid", 32'(out_valid), 32'd1);
    held = out;
    check("bp_value", held, 32'h0000_00FF);
    a = 32'h8000_0000; movement = 32'd1; arith = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
        check("bp_stall", {out_valid, in_ready, 30'd0}, 32'h8000_0000);
    end
    check("bp_stall_end", {30'd0, out_valid, in_ready}, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);
    check("bp_idle_out", out, held);
    tick();
    in_valid = 1'b0;
    check("bp_accept", {29'd0, out_valid, busy, in_ready}, 32'd2);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("bp_second_lat", 32'(guard), 32'd5);
    check("bp_second", out, 32'hC000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset aborts during the third SHIFT cycle.
    a = 32'hDEAD_BEEF; movement = 32'd3; arith = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 32'd0);
    check("abort_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op("post_rst", 32'hF0F0_F0F0, 32'd8, 1'b0, 32'h00F0_F0F0, 0, 1'b0);

    // Random operations with random stalls and out_ready noise.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rm = $urandom; rr = 1'($urandom);
      do_op("rand", ra, rm, rr, ref_shift(ra, rm, rr), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
